// File: rtl/hamming_biriktirici.sv
// Sequential Hamming-distance accumulator with saturating running sum.
// Optional build macro HD_TEK_CEVRIM_EN: single-cycle full 32-bit popcount instead of the SAY loop.
module hamming_biriktirici #(
  parameter int unsigned ADIM_BIT  = 4,
  parameter int unsigned BIRIKIM_W = 16
) (
  input  logic                 clk_i,
  input  logic                 rst_ni,
  input  logic                 istek_gecerli_i,
  output logic                 istek_hazir_o,
  input  logic [31:0]          deger1_i,
  input  logic [31:0]          deger2_i,
  input  logic                 biriktir_i,
  input  logic                 temizle_i,
  output logic                 sonuc_gecerli_o,
  input  logic                 sonuc_hazir_i,
  output logic [BIRIKIM_W-1:0] sonuc_o,
  output logic                 doygun_o,
  output logic                 mesgul_o
);

  typedef enum logic [1:0] {BOS, SAY, SONUC} durum_t;

  durum_t               durum;
  durum_t               durum_sonraki;

  logic [31:0]          fark;
  logic                 kabul;
  logic [BIRIKIM_W-1:0] birikim;
  logic                 doygun;

  logic                 commit;
  logic [5:0]           mesafe;
  logic                 mod_biriktir;
  logic [BIRIKIM_W-1:0] taban;
  logic [BIRIKIM_W:0]   toplam;
  logic [BIRIKIM_W-1:0] commit_deger;
  logic                 commit_doygun;

  assign fark  = deger1_i ^ deger2_i;
  assign kabul = istek_gecerli_i & istek_hazir_o;

`ifdef HD_TEK_CEVRIM_EN

  function automatic logic [5:0] popcount32(input logic [31:0] v);
    logic [5:0] s;
    s = '0;
    for (int unsigned i = 0; i < 32; i++) s = s + 6'(v[i]);
    return s;
  endfunction

  always_comb begin
    commit       = kabul;
    mesafe       = popcount32(fark);
    mod_biriktir = biriktir_i;
  end

`else

  logic [31:0] kalan;
  logic [31:0] kalan_sonraki;
  logic [5:0]  ara_toplam;
  logic [5:0]  ara_sonraki;
  logic        biriktir;

  function automatic logic [5:0] adim_say(input logic [31:0] v);
    logic [5:0] s;
    s = '0;
    for (int unsigned i = 0; i < ADIM_BIT; i++) s = s + 6'(v[i]);
    return s;
  endfunction

  always_comb begin
    kalan_sonraki = kalan >> ADIM_BIT;
    ara_sonraki   = ara_toplam + adim_say(kalan);
  end

  // Equal operands commit straight from BOS with the live biriktir_i, since the latch is not yet loaded.
  always_comb begin
    commit       = 1'b0;
    mesafe       = '0;
    mod_biriktir = biriktir;
    case (durum)
      BOS: begin
        commit       = kabul && (fark == '0);
        mod_biriktir = biriktir_i;
      end
      SAY: begin
        commit = (kalan_sonraki == '0);
        mesafe = ara_sonraki;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      kalan      <= '0;
      ara_toplam <= '0;
      biriktir   <= 1'b0;
    end else if (durum == BOS) begin
      if (kabul) begin
        kalan      <= fark;
        ara_toplam <= '0;
        biriktir   <= biriktir_i;
      end
    end else if (durum == SAY) begin
      kalan      <= kalan_sonraki;
      ara_toplam <= ara_sonraki;
    end
  end

`endif

  // A clear seen in BOS is folded into the base so a same-cycle accumulate starts from zero.
  always_comb begin
    taban  = (durum == BOS && temizle_i) ? '0 : birikim;
    toplam = {1'b0, taban} + (BIRIKIM_W+1)'(mesafe);
    if (mod_biriktir) begin
      commit_doygun = toplam[BIRIKIM_W];
      commit_deger  = toplam[BIRIKIM_W] ? '1 : toplam[BIRIKIM_W-1:0];
    end else begin
      commit_doygun = 1'b0;
      commit_deger  = BIRIKIM_W'(mesafe);
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      birikim <= '0;
      doygun  <= 1'b0;
    end else if (commit) begin
      birikim <= commit_deger;
      doygun  <= commit_doygun;
    end else if (durum == BOS && temizle_i) begin
      birikim <= '0;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) durum <= BOS;
    else         durum <= durum_sonraki;
  end

  always_comb begin
    durum_sonraki = durum;
    case (durum)
      BOS: begin
        if (kabul) durum_sonraki = commit ? SONUC : SAY;
      end
      SAY: begin
        if (commit) durum_sonraki = SONUC;
      end
      SONUC: begin
        if (sonuc_hazir_i) durum_sonraki = BOS;
      end
      default: durum_sonraki = BOS;
    endcase
  end

  always_comb begin
    istek_hazir_o   = (durum == BOS);
    sonuc_gecerli_o = (durum == SONUC);
`ifdef HD_TEK_CEVRIM_EN
    mesgul_o        = 1'b0;
`else
    mesgul_o        = (durum == SAY);
`endif
    sonuc_o         = birikim;
    doygun_o        = doygun;
  end

endmodule

// File: tb/tb_hamming_biriktirici.sv
// Scoreboard bench: default-width and 6-bit accumulator instances driven in lockstep.
module tb_hamming_biriktirici;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        gec = 1'b0;
  logic [31:0] d1 = '0;
  logic [31:0] d2 = '0;
  logic        bir = 1'b0;
  logic        tem = 1'b0;
  logic [1:0]  chz = 2'b11;
  logic [1:0]  ireq, val, doy, mes;
  logic [15:0] son0;
  logic [5:0]  son6;

  always #5 clk = ~clk;

  hamming_biriktirici #(.ADIM_BIT(4), .BIRIKIM_W(16)) u0 (
    .clk_i(clk), .rst_ni(rst_n), .istek_gecerli_i(gec), .istek_hazir_o(ireq[0]),
    .deger1_i(d1), .deger2_i(d2), .biriktir_i(bir), .temizle_i(tem),
    .sonuc_gecerli_o(val[0]), .sonuc_hazir_i(chz[0]), .sonuc_o(son0),
    .doygun_o(doy[0]), .mesgul_o(mes[0]));

  hamming_biriktirici #(.ADIM_BIT(4), .BIRIKIM_W(6)) u1 (
    .clk_i(clk), .rst_ni(rst_n), .istek_gecerli_i(gec), .istek_hazir_o(ireq[1]),
    .deger1_i(d1), .deger2_i(d2), .biriktir_i(bir), .temizle_i(tem),
    .sonuc_gecerli_o(val[1]), .sonuc_hazir_i(chz[1]), .sonuc_o(son6),
    .doygun_o(doy[1]), .mesgul_o(mes[1]));

  typedef struct {
    logic [31:0] a;
    logic [31:0] b;
    logic        acc;
    logic        clr;
    logic [15:0] e16;
    logic        d16;
    logic [15:0] e6;
    logic        d6;
    int          k;
    logic        bp;
  } vec_t;

  typedef struct {
    logic [15:0] v;
    logic        d;
    int          k;
    logic        bp;
    int          acc_cyc;
  } exp_t;

  // Hand-computed: a, b, accumulate, clear, result/sat (W=16), result/sat (W=6), k, backpressure
  vec_t tbl [12] = '{
    '{32'hFFFFFFFF, 32'h00000000, 1'b0, 1'b0, 16'd32, 1'b0, 16'd32, 1'b0, 8, 1'b0},
    '{32'h12345678, 32'h12345678, 1'b0, 1'b0, 16'd0,  1'b0, 16'd0,  1'b0, 0, 1'b0},
    '{32'h00000001, 32'h00000000, 1'b0, 1'b0, 16'd1,  1'b0, 16'd1,  1'b0, 1, 1'b0},
    '{32'h0000000F, 32'h00000000, 1'b1, 1'b0, 16'd5,  1'b0, 16'd5,  1'b0, 1, 1'b0},
    '{32'h80000000, 32'h00000000, 1'b1, 1'b0, 16'd6,  1'b0, 16'd6,  1'b0, 8, 1'b0},
    '{32'hFFFFFFFF, 32'h00000000, 1'b0, 1'b0, 16'd32, 1'b0, 16'd32, 1'b0, 8, 1'b0},
    '{32'hFFFFFFFF, 32'h00000000, 1'b1, 1'b0, 16'd64, 1'b0, 16'd63, 1'b1, 8, 1'b0},
    '{32'h00000003, 32'h00000000, 1'b0, 1'b0, 16'd2,  1'b0, 16'd2,  1'b0, 1, 1'b0},
    '{32'hFFFFFFFF, 32'h00000000, 1'b1, 1'b0, 16'd34, 1'b0, 16'd34, 1'b0, 8, 1'b1},
    '{32'h00000003, 32'h00000000, 1'b1, 1'b1, 16'd2,  1'b0, 16'd2,  1'b0, 1, 1'b0},
    '{32'h00000000, 32'h00000000, 1'b1, 1'b1, 16'd0,  1'b0, 16'd0,  1'b0, 0, 1'b0},
    '{32'h00F00100, 32'h00000001, 1'b0, 1'b0, 16'd6,  1'b0, 16'd6,  1'b0, 6, 1'b0}
  };

  exp_t q0[$];
  exp_t q1[$];
  int   checks = 0;
  int   passed = 0;
  int   cyc = 0;
  int   stall [2] = '{0, 0};
  int   mes_cnt [2] = '{0, 0};
  logic pv [2] = '{1'b0, 1'b0};
  exp_t hold [2];

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string nm, input int i, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act === exp) passed++;
    else $display("FAIL %s inst%0d: got %0d (0x%0h), required %0d (0x%0h) at %0t",
                  nm, i, act, act, exp, exp, $time);
  endtask

  function automatic logic [31:0] son_of(input int i);
    return (i == 0) ? {16'd0, son0} : {26'd0, son6};
  endfunction

  // Monitor: consumer side, owns sonuc_hazir_i and pops the scoreboard on each new result.
  always @(negedge clk) begin
    exp_t e;
    logic have;
    for (int i = 0; i < 2; i++) begin
      have = 1'b0;
      if (mes[i]) mes_cnt[i]++;
      if (val[i] && !pv[i]) begin
        if (i == 0 && q0.size() > 0) begin e = q0.pop_front(); have = 1'b1; end
        if (i == 1 && q1.size() > 0) begin e = q1.pop_front(); have = 1'b1; end
        if (!have) begin
          checks++;
          $display("FAIL unexpected_result inst%0d: got valid result %0d, required none at %0t",
                   i, son_of(i), $time);
        end else begin
          chk("sonuc", i, son_of(i), {16'd0, e.v});
          chk("doygun", i, {31'd0, doy[i]}, {31'd0, e.d});
          chk("latency", i, cyc - e.acc_cyc, e.k);
          chk("busy_cycles", i, mes_cnt[i], e.k);
          if (e.bp) begin
            stall[i] = 5;
            hold[i]  = e;
          end
        end
        mes_cnt[i] = 0;
      end else if (val[i] && stall[i] > 0) begin
        chk("stall_sonuc", i, son_of(i), {16'd0, hold[i].v});
        chk("stall_doygun", i, {31'd0, doy[i]}, {31'd0, hold[i].d});
        chk("stall_istek_hazir", i, {31'd0, ireq[i]}, 32'd0);
        stall[i]--;
      end
      pv[i] = val[i];
    end
    chz[0] = (stall[0] == 0);
    chz[1] = (stall[1] == 0);
  end

  task automatic wait_ready(output logic ok);
    int n;
    n = 0;
    while (!(ireq[0] && ireq[1]) && n < 200) begin
      @(posedge clk); #1;
      n++;
    end
    ok = (n < 200);
    if (!ok) begin
      checks++;
      $display("FAIL accept_timeout: got no istek_hazir_o within %0d cycles, required ready", n);
    end
  endtask

  task automatic send(input vec_t v);
    exp_t e;
    logic ok;
    d1 = v.a; d2 = v.b; bir = v.acc; tem = v.clr; gec = 1'b1;
    wait_ready(ok);
    if (ok) begin
      @(posedge clk); #1;
`ifdef HD_TEK_CEVRIM_EN
      e.k = 0;
`else
      e.k = v.k;
`endif
      e.bp = v.bp; e.acc_cyc = cyc;
      e.v = v.e16; e.d = v.d16; q0.push_back(e);
      e.v = v.e6;  e.d = v.d6;  q1.push_back(e);
    end
    gec = 1'b0; tem = 1'b0;
  endtask

  task automatic check_reset_outputs(input string tag);
    for (int i = 0; i < 2; i++) begin
      chk({tag, "_sonuc"}, i, son_of(i), 32'd0);
      chk({tag, "_doygun"}, i, {31'd0, doy[i]}, 32'd0);
      chk({tag, "_sonuc_gecerli"}, i, {31'd0, val[i]}, 32'd0);
      chk({tag, "_mesgul"}, i, {31'd0, mes[i]}, 32'd0);
      chk({tag, "_istek_hazir"}, i, {31'd0, ireq[i]}, 32'd1);
    end
  endtask

  initial begin
    int n;
    logic ok;
    repeat (3) @(posedge clk);
    #1;
    check_reset_outputs("reset");
    rst_n = 1'b1;
    @(posedge clk); #1;

    foreach (tbl[j]) send(tbl[j]);

    n = 0;
    while ((q0.size() != 0 || q1.size() != 0) && n < 200) begin
      @(posedge clk); #1;
      n++;
    end
    chk("scoreboard_drained", 0, q0.size() + q1.size(), 32'd0);

    // Abort a full-difference count partway through with an asynchronous reset.
    d1 = 32'hFFFFFFFF; d2 = '0; bir = 1'b1; tem = 1'b0; gec = 1'b1;
    wait_ready(ok);
    if (ok) begin
      @(posedge clk); #1;
      gec = 1'b0;
`ifndef HD_TEK_CEVRIM_EN
      repeat (2) @(posedge clk);
      #1;
      chk("mid_say_mesgul", 0, {31'd0, mes[0]}, 32'd1);
`endif
      rst_n = 1'b0;
      #1;
      check_reset_outputs("midrst");
      repeat (2) @(posedge clk);
      #1;
      rst_n = 1'b1;
      repeat (12) @(posedge clk);
      #1;
      check_reset_outputs("post_rst");
    end
    gec = 1'b0;

    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got simulation still running at %0t, required completion", $time);
    $fatal(1, "watchdog expired");
  end

endmodule

// File: doc/hamming_biriktirici.md
# hamming_biriktirici

Sequential Hamming-distance accumulator for the X-extension crypto unit (sifreleme_birimi) in the execute stage. Accepts two 32-bit operands over a valid/ready handshake and counts differing bits iteratively, ADIM_BIT bits per cycle, with early exit once no set bits remain. Either returns the distance or adds it, with saturation, to an internal running sum. Results are presented on a second valid/ready handshake to the execute-stage writeback path.

## Interface
- ADIM_BIT, 4, bits counted per SAY cycle; must be one of 1, 2, 4, 8, 16, 32.
- BIRIKIM_W, 16, accumulator and result width; must be ≥ 6.
- clk_i  in  1  clock; all state updates on the rising edge.
- rst_ni  in  1  asynchronous active-low reset.
- istek_gecerli_i  in  1  request valid.
- istek_hazir_o  out  1  request ready; equals (durum == BOS).
- deger1_i  in  32  operand 1.
- deger2_i  in  32  operand 2.
- biriktir_i  in  1  1: add distance to accumulator; 0: load distance.
- temizle_i  in  1  clear accumulator; honoured only in BOS.
- sonuc_gecerli_o  out  1  result valid; equals (durum == SONUC).
- sonuc_hazir_i  in  1  consumer ready.
- sonuc_o  out  BIRIKIM_W  accumulator value.
- doygun_o  out  1  saturation occurred in the last completed operation.
- mesgul_o  out  1  equals (durum == SAY).

## Operation
- **Accept:** accept = istek_gecerli_i & istek_hazir_o.
- **On accept:**
  - kalan <= deger1_i ^ deger2_i.
  - ara_toplam <= 0.
  - biriktir_i is latched.
- **States:**
  - BOS: on accept, go to SAY if the XOR is nonzero; otherwise go to SONUC with distance 0.
  - SAY: each cycle, ara_toplam += popcount(kalan[ADIM_BIT-1:0]) and kalan >>= ADIM_BIT. When the shifted kalan is 0, commit and go to SONUC.
  - SONUC: hold all outputs; if sonuc_hazir_i, go to BOS.
- **Commit** (on entry to SONUC), with d = distance:
  - Latched biriktir = 0: birikim <= d, doygun <= 0.
  - Latched biriktir = 1: birikim <= min(birikim + d, 2^BIRIKIM_W − 1), computed at BIRIKIM_W+1 bits. doygun <= 1 iff clamped.
- **temizle_i in BOS:**
  - Sets birikim to 0.
  - If temizle_i and accept occur in the same cycle, the clear applies first and a latched accumulate starts from 0.
  - Ignored in SAY and SONUC.
- **Output:** sonuc_o = birikim at all times.

## Timing
- **Reset values:** durum = BOS, birikim = 0, sonuc_o = 0, doygun_o = 0, sonuc_gecerli_o = 0, mesgul_o = 0, istek_hazir_o = 1.
- **Latency:**
  - Let k = ceil((index of highest set XOR bit + 1) / ADIM_BIT), with k = 0 for equal operands.
  - sonuc_gecerli_o rises k edges after the accept edge; k = 0 means it is high in the cycle right after accept.
  - Worst case is 32/ADIM_BIT; 8 with the defaults.
- **Backpressure:** sonuc_o and doygun_o stay stable while sonuc_gecerli_o is high and sonuc_hazir_i is low. istek_hazir_o stays 0 until the SONUC→BOS edge.
- **Throughput:** a result handshake and a new accept cannot occur in the same cycle. Minimum spacing between accepts is k + 2 cycles.
- **Reset mid-operation:** asserting rst_ni low in any state discards the operation immediately and clears the accumulator. No result is produced.

## Configuration
- **HD_TEK_CEVRIM_EN defined:**
  - On accept, the full 32-bit popcount of the XOR is computed combinationally.
  - The state goes directly to SONUC, so k = 0 always.
  - The SAY state and ADIM_BIT are unused and mesgul_o is tied to 0.
- **Not defined:** iterative SAY datapath as described above, and the default build.
- Commit, saturation and handshake behaviour are identical in both builds.

## Test plan
1. **Full difference, load mode:** defaults, deger1_i=0xFFFFFFFF, deger2_i=0, biriktir_i=0 → mesgul_o high 8 cycles, sonuc_o=32, doygun_o=0.
2. **Equal operands:** deger1_i=deger2_i=0x12345678 → sonuc_gecerli_o high in the cycle after accept, sonuc_o=0, mesgul_o never high.
3. **Accumulate and early exit:**
   - 0x00000001 vs 0 with biriktir_i=0 → k=1, sonuc_o=1.
   - Then 0x0000000F vs 0 with biriktir_i=1 → sonuc_o=5.
   - Then 0x80000000 vs 0 with biriktir_i=1 → k=8, sonuc_o=6.
4. **Saturation:**
   - BIRIKIM_W=6: 0xFFFFFFFF vs 0 with biriktir_i=0 → 32.
   - Repeat with biriktir_i=1 → sonuc_o=63, doygun_o=1.
   - Next load of 0x3 vs 0 → sonuc_o=2, doygun_o=0.
5. **Backpressure and clear:**
   - Hold sonuc_hazir_i=0 for 5 cycles → sonuc_o stable, istek_hazir_o=0, a pending request is not accepted until after the release edge.
   - In BOS, temizle_i together with an accept of 0x3 vs 0 and biriktir_i=1 → sonuc_o=2.
6. **Reset mid-SAY:** pull rst_ni low during cycle 3 of a 0xFFFFFFFF vs 0 count → all outputs at reset values immediately, no sonuc_gecerli_o pulse. Repeat the scenario with HD_TEK_CEVRIM_EN defined.
